// File: rtl/sb_dmem_pkg.sv
// Shared constants, state encoding and lane-steering helpers for the sb data memory.
package sb_dmem_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int BYTE_SEL       = 2;

  localparam logic [BYTE_SEL-1:0] SL_BYTE = 2'b00;
  localparam logic [BYTE_SEL-1:0] SL_HALF = 2'b01;
  localparam logic [BYTE_SEL-1:0] SL_WORD = 2'b10;
  localparam logic [BYTE_SEL-1:0] SL_NONE = 2'b11;

  localparam logic SIGNED   = 1'b0;
  localparam logic UNSIGNED = 1'b1;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [DATA_WIDTH-1:0]     ZERO32   = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Half-words need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [BYTE_SEL-1:0] sel);
    return ((sel == SL_HALF) && lsb[0]) || ((sel == SL_WORD) && (lsb != 2'b00));
  endfunction

  // Byte-write enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_be(input logic [1:0] lsb, input logic [BYTE_SEL-1:0] sel);
    logic [3:0] be;
    case (sel)
      SL_BYTE: be = 4'b0001 << lsb;
      SL_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
      SL_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-justified store data onto every lane it may land in.
  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [DATA_WIDTH-1:0] wdata,
                                                       input logic [BYTE_SEL-1:0] sel);
    logic [DATA_WIDTH-1:0] d;
    case (sel)
      SL_BYTE: d = {4{wdata[7:0]}};
      SL_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Shift the selected lane(s) down to bit 0 and sign/zero extend.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] lsb,
                                                        input logic [BYTE_SEL-1:0] sel,
                                                        input logic uns);
    logic [7:0]            b;
    logic [15:0]           h;
    logic                  sx;
    logic [DATA_WIDTH-1:0] r;
    case (lsb)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = lsb[1] ? word[31:16] : word[15:0];
    sx = (uns == SIGNED);
    case (sel)
      SL_BYTE: r = {{24{sx & b[7]}}, b};
      SL_HALF: r = {{16{sx & h[15]}}, h};
      SL_WORD: r = word;
      default: r = ZERO32;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_ram_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module sb_ram_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Commit each enabled byte lane; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Capture a new word only when a read is requested, otherwise hold it.
  always_comb begin
    rdata_d = re ? mem[raddr] : rdata_q;
  end

  // Read data register feeding the lane steering in the parent.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sb_dmem.sv
// Data-memory responder: stores in one cycle, loads with a fixed latency and a pipeline hold.
module sb_dmem
  import sb_dmem_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter logic [31:0] BASE     = 32'h1000_0000,
  parameter int          READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_re,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  input  logic                      mem_we,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [BYTE_SEL-1:0]       byte_sel,
  input  logic                      un_sign,
  input  logic [REG_ADDR_WIDTH-1:0] rd_waddr,
  output logic                      hold_o,
  output logic                      rvalid_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_waddr_o,
  output logic [DATA_WIDTH-1:0]     rd_wdata_o,
  output logic                      err_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [1:0]  CNT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_e                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BYTE_SEL-1:0]         sel_q, sel_d;
  logic                        uns_q, uns_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                        bad_q, bad_d;
  logic                        err_q, err_d;

  logic [31:0]   woff, roff, qoff;
  logic          st_bad, ld_bad;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          ram_re;

  // Offsets from BASE; wrap-around makes addresses below BASE look huge and fail the range test.
  assign woff = mem_waddr - BASE;
  assign roff = mem_raddr - BASE;
  assign qoff = addr_q - BASE;

  // A sized access is illegal when it leaves the window or is misaligned; SL_NONE never is.
  assign st_bad = (byte_sel != SL_NONE) &&
                  ((woff >= SPAN) || is_misaligned(mem_waddr[1:0], byte_sel));
  assign ld_bad = (byte_sel != SL_NONE) &&
                  ((roff >= SPAN) || is_misaligned(mem_raddr[1:0], byte_sel));

  // Next-state, request acceptance, store steering and RAM read scheduling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    uns_d     = uns_q;
    rd_d      = rd_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    hold_o    = 1'b0;
    ram_be    = 4'b0000;
    ram_waddr = woff[AW+1:2];
    ram_wdata = store_data(mem_wdata, byte_sel);
    ram_re    = 1'b0;
    ram_raddr = qoff[AW+1:2];
    case (state_q)
      ST_IDLE: begin
        if (mem_we) begin
          if (!st_bad) ram_be = store_be(mem_waddr[1:0], byte_sel);
          err_d = st_bad | mem_re;
        end else if (mem_re) begin
          hold_o = 1'b1;
          addr_d = mem_raddr;
          sel_d  = byte_sel;
          uns_d  = un_sign;
          rd_d   = rd_waddr;
          bad_d  = ld_bad;
          err_d  = ld_bad;
          if (READ_LAT > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d   = ST_DONE;
            ram_re    = 1'b1;
            ram_raddr = roff[AW+1:2];
          end
        end
      end
      ST_WAIT: begin
        hold_o = 1'b1;
        err_d  = mem_we;
        if (cnt_q == 2'd0) begin
          state_d = ST_DONE;
          ram_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and load-context registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      sel_q   <= SL_NONE;
      uns_q   <= SIGNED;
      rd_q    <= ZERO_REG;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  sb_ram_bank #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .be     (ram_be),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata_o(ram_rdata)
  );

  assign rvalid_o   = (state_q == ST_DONE);
  assign rd_waddr_o = rvalid_o ? rd_q : ZERO_REG;
  assign rd_wdata_o = (rvalid_o && !bad_q) ? load_extend(ram_rdata, addr_q[1:0], sel_q, uns_q)
                                           : ZERO32;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sb_dmem.sv
// Directed bench for sb_dmem: one READ_LAT=1 and one READ_LAT=3 instance share the store bus.
module tb_sb_dmem;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [1:0]  SB    = 2'b00;
  localparam logic [1:0]  SH    = 2'b01;
  localparam logic [1:0]  SW    = 2'b10;
  localparam logic [1:0]  SN    = 2'b11;

  logic        clk;
  logic        rst;
  logic        mem_re1, mem_re3;
  logic [31:0] mem_raddr;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [1:0]  byte_sel;
  logic        un_sign;
  logic [4:0]  rd_waddr;

  logic        hold1, rvalid1, err1;
  logic [4:0]  rd1;
  logic [31:0] data1;
  logic        hold3, rvalid3, err3;
  logic [4:0]  rd3;
  logic [31:0] data3;

  int checks   = 0;
  int failures = 0;

  sb_dmem #(.DEPTH(DEPTH), .BASE(BASE), .READ_LAT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .mem_re    (mem_re1),
    .mem_raddr (mem_raddr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .byte_sel  (byte_sel),
    .un_sign   (un_sign),
    .rd_waddr  (rd_waddr),
    .hold_o    (hold1),
    .rvalid_o  (rvalid1),
    .rd_waddr_o(rd1),
    .rd_wdata_o(data1),
    .err_o     (err1)
  );

  sb_dmem #(.DEPTH(DEPTH), .BASE(BASE), .READ_LAT(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .mem_re    (mem_re3),
    .mem_raddr (mem_raddr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .byte_sel  (byte_sel),
    .un_sign   (un_sign),
    .rd_waddr  (rd_waddr),
    .hold_o    (hold3),
    .rvalid_o  (rvalid3),
    .rd_waddr_o(rd3),
    .rd_wdata_o(data3),
    .err_o     (err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's worth of inputs at the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic [1:0] sel, input logic uns,
                               input logic re1, input logic re3,
                               input logic [31:0] raddr, input logic [4:0] rd);
    @(negedge clk);
    mem_we    = we;
    mem_waddr = waddr;
    mem_wdata = wdata;
    byte_sel  = sel;
    un_sign   = uns;
    mem_re1   = re1;
    mem_re3   = re3;
    mem_raddr = raddr;
    rd_waddr  = rd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, SN, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0;
    idleCycle();
    idleCycle();
    checkOutput("rst_hold1",   32'(hold1),   32'h0);
    checkOutput("rst_rvalid1", 32'(rvalid1), 32'h0);
    checkOutput("rst_rd1",     32'(rd1),     32'h0);
    checkOutput("rst_data1",   data1,        32'h0);
    checkOutput("rst_err1",    32'(err1),    32'h0);
    checkOutput("rst_hold3",   32'(hold3),   32'h0);
    checkOutput("rst_rvalid3", 32'(rvalid3), 32'h0);
    rst = 1'b1;
    idleCycle();

    $display("[TB] word store then signed/unsigned byte loads");
    applyStimulus(1'b1, BASE, 32'hDEAD_BEEF, SW, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    checkOutput("st_word_hold", 32'(hold1), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SB, 1'b0, 1'b1, 1'b0, BASE + 32'd3, 5'd5);
    checkOutput("st_word_err", 32'(err1), 32'h0);
    checkOutput("ldb_c0_hold", 32'(hold1), 32'h1);
    checkOutput("ldb_c0_rvalid", 32'(rvalid1), 32'h0);
    idleCycle();
    checkOutput("ldb_c1_rvalid", 32'(rvalid1), 32'h1);
    checkOutput("ldb_c1_hold", 32'(hold1), 32'h0);
    checkOutput("ldb_c1_rd", 32'(rd1), 32'd5);
    checkOutput("ldb_c1_data", data1, 32'hFFFF_FFDE);
    checkOutput("ldb_c1_err", 32'(err1), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SB, 1'b1, 1'b1, 1'b0, BASE + 32'd3, 5'd6);
    checkOutput("ldbu_c0_hold", 32'(hold1), 32'h1);
    idleCycle();
    checkOutput("ldbu_c1_data", data1, 32'h0000_00DE);
    checkOutput("ldbu_c1_rd", 32'(rd1), 32'd6);
    idleCycle();
    checkOutput("after_rvalid", 32'(rvalid1), 32'h0);
    checkOutput("after_rd", 32'(rd1), 32'h0);
    checkOutput("after_data", data1, 32'h0);

    $display("[TB] half and byte stores merged into a word");
    applyStimulus(1'b1, BASE + 32'd4, 32'h1234_5678, SW, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    applyStimulus(1'b1, BASE + 32'd6, 32'h0000_8001, SH, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, SH, 1'b0, 1'b1, 1'b0, BASE + 32'd6, 5'd7);
    idleCycle();
    checkOutput("ldh_data", data1, 32'hFFFF_8001);
    checkOutput("ldh_rd", 32'(rd1), 32'd7);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b1, 1'b0, BASE + 32'd4, 5'd9);
    idleCycle();
    checkOutput("ldw_data", data1, 32'h8001_5678);
    applyStimulus(1'b1, BASE + 32'd5, 32'h0000_00A5, SB, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b1, 1'b1, 1'b0, BASE + 32'd4, 5'd9);
    idleCycle();
    checkOutput("ldw_byte_merge", data1, 32'h8001_A578);

    $display("[TB] three-cycle load held on the bus, store attempted while waiting");
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b0, 1'b1, BASE + 32'd4, 5'd3);
    checkOutput("lat3_c0_hold", 32'(hold3), 32'h1);
    checkOutput("lat3_c0_rvalid", 32'(rvalid3), 32'h0);
    applyStimulus(1'b1, BASE + 32'd8, 32'h5555_AAAA, SW, 1'b0, 1'b0, 1'b1, BASE + 32'd4, 5'd3);
    checkOutput("lat3_c1_hold", 32'(hold3), 32'h1);
    checkOutput("lat3_c1_rvalid", 32'(rvalid3), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b0, 1'b1, BASE + 32'd4, 5'd3);
    checkOutput("lat3_c2_hold", 32'(hold3), 32'h1);
    checkOutput("lat3_c2_rvalid", 32'(rvalid3), 32'h0);
    checkOutput("lat3_wait_store_err", 32'(err3), 32'h1);
    checkOutput("lat3_idle_store_err", 32'(err1), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b0, 1'b1, BASE + 32'd4, 5'd3);
    checkOutput("lat3_c3_hold", 32'(hold3), 32'h0);
    checkOutput("lat3_c3_rvalid", 32'(rvalid3), 32'h1);
    checkOutput("lat3_c3_rd", 32'(rd3), 32'd3);
    checkOutput("lat3_c3_data", data3, 32'h8001_A578);
    checkOutput("lat3_c3_err", 32'(err3), 32'h0);
    idleCycle();
    checkOutput("lat3_c4_rvalid", 32'(rvalid3), 32'h0);
    checkOutput("lat3_c4_hold", 32'(hold3), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b1, 1'b0, BASE + 32'd8, 5'd2);
    idleCycle();
    checkOutput("lat1_store_during_other_wait", data1, 32'h5555_AAAA);

    $display("[TB] misaligned and out-of-range requests");
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b1, 1'b0, BASE + 32'd2, 5'd4);
    checkOutput("badld_c0_hold", 32'(hold1), 32'h1);
    idleCycle();
    checkOutput("badld_rvalid", 32'(rvalid1), 32'h1);
    checkOutput("badld_rd", 32'(rd1), 32'd4);
    checkOutput("badld_data", data1, 32'h0);
    checkOutput("badld_err", 32'(err1), 32'h1);
    idleCycle();
    checkOutput("badld_err_pulse", 32'(err1), 32'h0);
    applyStimulus(1'b1, BASE + 32'(4 * DEPTH), 32'hCAFE_F00D, SW, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    idleCycle();
    checkOutput("oor_store_err", 32'(err1), 32'h1);
    applyStimulus(1'b1, BASE + 32'd1, 32'h0000_FFFF, SH, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    checkOutput("oor_store_err_pulse", 32'(err1), 32'h0);
    applyStimulus(1'b1, BASE - 32'd4, 32'h1111_1111, SW, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    checkOutput("mis_store_err", 32'(err1), 32'h1);
    applyStimulus(1'b1, BASE + 32'(4 * DEPTH), 32'h2222_2222, SN, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    checkOutput("below_store_err", 32'(err1), 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b1, 1'b0, BASE, 5'd1);
    checkOutput("none_store_no_err", 32'(err1), 32'h0);
    idleCycle();
    checkOutput("mem_unchanged", data1, 32'hDEAD_BEEF);

    $display("[TB] simultaneous load and store");
    applyStimulus(1'b1, BASE + 32'd12, 32'h0BAD_F00D, SW, 1'b0, 1'b1, 1'b0, BASE + 32'd12, 5'd8);
    checkOutput("rewe_hold", 32'(hold1), 32'h0);
    idleCycle();
    checkOutput("rewe_err", 32'(err1), 32'h1);
    checkOutput("rewe_no_rvalid", 32'(rvalid1), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b1, 1'b0, BASE + 32'd12, 5'd8);
    idleCycle();
    checkOutput("rewe_store_committed", data1, 32'h0BAD_F00D);

    $display("[TB] reset during a pending load");
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b0, 1'b1, BASE, 5'd10);
    applyStimulus(1'b0, 32'h0, 32'h0, SW, 1'b0, 1'b0, 1'b1, BASE, 5'd10);
    checkOutput("rstwait_hold_before", 32'(hold3), 32'h1);
    rst = 1'b0;
    idleCycle();
    rst = 1'b1;
    checkOutput("rstwait_hold_after", 32'(hold3), 32'h0);
    checkOutput("rstwait_rvalid_c2", 32'(rvalid3), 32'h0);
    idleCycle();
    checkOutput("rstwait_rvalid_c3", 32'(rvalid3), 32'h0);
    idleCycle();
    checkOutput("rstwait_rvalid_c4", 32'(rvalid3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
